// File: rtl/mac_controller_pkg.sv
// Shared state encoding and count width for the dot-product MAC controller.
// latency: n/a; backpressure: n/a.
package mac_controller_pkg;

    localparam int CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mac_controller_if.sv
// Run-control and operand handshake bundle between a host and the MAC controller.
// latency: n/a; backpressure: in_ready qualifies in_valid.
interface mac_controller_if;
    import mac_controller_pkg::*;

    logic start;
    cnt_t length;
    logic abort;
    logic in_valid;
    logic in_ready;
    logic op_enable;
    logic acc_enable;
    logic acc_clear;
    logic busy;
    logic done;
    cnt_t count;

    modport master (
        output start, length, abort, in_valid,
        input  in_ready, op_enable, acc_enable, acc_clear, busy, done, count
    );

    modport slave (
        input  start, length, abort, in_valid,
        output in_ready, op_enable, acc_enable, acc_clear, busy, done, count
    );

endinterface

// File: rtl/mac_counter.sv
// Operand-pair counter: synchronous clear wins over increment, async reset.
// latency: count updates one edge after clr/inc; backpressure: none.
module mac_counter
    import mac_controller_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output cnt_t count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + cnt_t'(1);
        end
    end

endmodule

// File: rtl/mac_controller.sv
// Sequences clear/load/accumulate for one dot-product run of 'length' operand pairs.
// latency: op_enable same cycle as transfer, acc_enable one cycle later; backpressure: in_ready only in LOAD.
module mac_controller
    import mac_controller_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mac_controller_if.slave  bus
);

    state_t state;
    state_t state_nxt;
    cnt_t   remaining;
    logic   acc_q;
    logic   xfer;
    logic   abort_act;
    logic   start_acc;

    always_comb begin
        abort_act = bus.abort &&
                    (state == ST_CLEAR || state == ST_LOAD || state == ST_DRAIN);
        // abort outranks a coincident transfer
        xfer      = (state == ST_LOAD) && bus.in_valid && !abort_act;
        start_acc = (state == ST_IDLE) && bus.start;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                if (abort_act)               state_nxt = ST_IDLE;
                else if (remaining != '0)    state_nxt = ST_LOAD;
                else                         state_nxt = ST_DONE;
            end
            ST_LOAD: begin
                if (abort_act)                              state_nxt = ST_IDLE;
                else if (xfer && remaining == cnt_t'(1))    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = abort_act ? ST_IDLE : ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            acc_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            acc_q <= xfer;
            if (start_acc) begin
                remaining <= bus.length;
            end else if (xfer) begin
                remaining <= remaining - cnt_t'(1);
            end
        end
    end

    mac_counter u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (start_acc),
        .inc   (xfer),
        .count (bus.count)
    );

    assign bus.in_ready   = (state == ST_LOAD);
    assign bus.op_enable  = xfer;
    assign bus.acc_enable = acc_q && !abort_act;
    assign bus.acc_clear  = (state == ST_CLEAR);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = (state == ST_DONE);

endmodule

// File: tb/tb_mac_controller.sv
// Scoreboard bench: stimulus pushes per-run expectations, a negedge monitor checks each run end.
// latency: n/a; backpressure: n/a.
module tb_mac_controller;
    import mac_controller_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mac_controller_if bus ();

    mac_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit exp_done;
        int exp_count;
        bit chk_ops;
        int exp_ops;
        bit chk_accs;
        int done_ofs;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"},   int'(bus.in_ready),   0);
        check({tag, "_op_enable"},  int'(bus.op_enable),  0);
        check({tag, "_acc_enable"}, int'(bus.acc_enable), 0);
        check({tag, "_acc_clear"},  int'(bus.acc_clear),  0);
        check({tag, "_busy"},       int'(bus.busy),       0);
        check({tag, "_done"},       int'(bus.done),       0);
        check({tag, "_count"},      int'(bus.count),      0);
    endtask

    // Monitor: counts pulses within a run and scores the run when busy falls.
    int ops = 0, accs = 0, dones = 0, cyc = 0, done_at = -1;
    bit prev_op = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (bus.acc_clear) begin
            ops = 0; accs = 0; dones = 0; cyc = 0; done_at = -1;
        end else begin
            cyc++;
        end
        if (bus.op_enable) begin
            ops++;
            check("op_handshake", int'(bus.in_valid & bus.in_ready), 1);
        end
        if (bus.acc_enable) begin
            accs++;
            check("acc_follows_op", int'(prev_op), 1);
        end else if (prev_op && !bus.abort && !reset) begin
            check("acc_after_op", int'(bus.acc_enable), 1);
        end
        if (bus.done) begin
            dones++;
            done_at = cyc;
        end
        if (prev_busy && !bus.busy) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_run_end actual=run_end required=none at %0t", $time);
            end else begin
                e = sbq.pop_front();
                check("done_pulses", dones, int'(e.exp_done));
                check("count", int'(bus.count), e.exp_count);
                if (e.chk_ops)      check("op_pulses", ops, e.exp_ops);
                if (e.chk_accs)     check("acc_pulses", accs, e.exp_ops);
                if (e.done_ofs >= 0) check("done_cycle", done_at, e.done_ofs);
            end
        end
        prev_op   = bus.op_enable;
        prev_busy = bus.busy;
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle at %0t", $time);
        end
        @(posedge clk); #1;
    endtask

    // mode 0: in_valid held high, 1: random gaps, 2: fixed 1,0,0,1,1,0,1 pattern.
    task automatic do_run(input int len, input int mode, input int abort_at, input bit extra_start);
        bit   pat[$];
        bit   fixed_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int   ones = 0;
        int   idx = 0;
        int   target;
        exp_t e;
        target = (abort_at > 0) ? abort_at : len;
        while (ones < target) begin
            bit b;
            case (mode)
                0:       b = 1'b1;
                1:       b = ($urandom_range(0, 2) != 0);
                default: b = fixed_pat[idx % 7];
            endcase
            if (b) ones++;
            pat.push_back(b);
            idx++;
        end
        e.exp_done  = (abort_at == 0);
        e.exp_count = (abort_at > 0) ? abort_at - 1 : len;
        e.chk_ops   = 1'b1;
        e.exp_ops   = e.exp_count;
        e.chk_accs  = (abort_at == 0);
        e.done_ofs  = (abort_at > 0) ? -1 : ((len == 0) ? 1 : pat.size() + 2);
        sbq.push_back(e);

        bus.start  = 1'b1;
        bus.length = cnt_t'(len);
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.length = cnt_t'($urandom);
        @(posedge clk); #1;
        for (int i = 0; i < pat.size(); i++) begin
            bus.in_valid = pat[i];
            if (abort_at > 0 && i == pat.size() - 1) bus.abort = 1'b1;
            if (extra_start && i == 2) begin
                bus.start  = 1'b1;
                bus.length = 8'd7;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
        end
        bus.in_valid = 1'b0;
        wait_idle();
    endtask

    task automatic reset_mid_load();
        exp_t e;
        e.exp_done  = 1'b0;
        e.exp_count = 0;
        e.chk_ops   = 1'b0;
        e.exp_ops   = 0;
        e.chk_accs  = 1'b0;
        e.done_ofs  = -1;
        sbq.push_back(e);
        bus.start  = 1'b1;
        bus.length = 8'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        #1 reset = 1'b1;
        #1 check_zero("async_reset");
        @(posedge clk); #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start    = 1'b0;
        bus.length   = '0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        #1 reset = 1'b1;
        #2 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        do_run(3, 0, 0, 1'b0);
        do_run(4, 2, 0, 1'b0);
        do_run(0, 0, 0, 1'b0);
        do_run(5, 0, 3, 1'b0);
        reset_mid_load();
        do_run(2, 0, 0, 1'b0);
        do_run(255, 0, 0, 1'b1);
        do_run(255, 1, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int len;
            int ab;
            len = int'($urandom_range(0, 20));
            ab  = 0;
            if (len > 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(1, len));
            do_run(len, 1, ab, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1 check("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
